// File: rtl/fast_keypoint_collector.sv
// rtl/fast_keypoint_collector.sv - FAST/NMS corner stream to queued (x, y) keypoints
// The output register is one of the Pra_Fifo_Depth slots, so Depth keypoints fit in total.

module fkc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wr_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

module fast_keypoint_collector #(
    parameter int Pra_Image_Width   = 640,
    parameter int Pra_Image_Height  = 480,
    parameter int Pra_Border        = 3,
    parameter int Pra_Max_Keypoints = 500,
    parameter int Pra_Fifo_Depth    = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fast_vs,
    input  logic        i_fast_hs,
    input  logic [7:0]  i_fast_data,
    output logic        o_kp_valid,
    input  logic        i_kp_ready,
    output logic [15:0] o_kp_x,
    output logic [15:0] o_kp_y,
    output logic [15:0] o_kp_count,
    output logic        o_overflow,
    output logic        o_frame_done
);
    localparam int CW = $clog2(Pra_Fifo_Depth);
    localparam logic [15:0] LO   = 16'(Pra_Border);
    localparam logic [15:0] X_HI = 16'(Pra_Image_Width - 1 - Pra_Border);
    localparam logic [15:0] Y_HI = 16'(Pra_Image_Height - 1 - Pra_Border);
    localparam logic [15:0] MAX  = 16'(Pra_Max_Keypoints);

    typedef enum logic [1:0] {IDLE, FRAME, FLUSH} state_t;

    state_t      state;
    logic        vs_d, hs_d;
    logic [15:0] x, y, cur_x, cur_y;
    logic        cand_v;
    logic [15:0] cand_x, cand_y;
    logic        vs_rise, vs_fall, hs_fall;
    logic        in_frame, in_border, hit;
    logic        push_req, queue_full, load, drained;
    logic [31:0] fifo_rd;
    logic [CW:0] fifo_count;
    logic        fifo_empty;
    logic [CW+1:0] occupancy;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign vs_rise  = i_fast_vs && !vs_d;
    assign vs_fall  = !i_fast_vs && vs_d;
    assign hs_fall  = !i_fast_hs && hs_d;
    assign cur_x    = vs_rise ? 16'd0 : x;
    assign cur_y    = vs_rise ? 16'd0 : y;
    // A frame already running when reset releases stays ignored until a fresh vs rise.
    assign in_frame = (state == FRAME) || vs_rise;
    assign in_border = (cur_x >= LO) && (cur_x <= X_HI) && (cur_y >= LO) && (cur_y <= Y_HI);
    assign hit      = i_fast_vs && i_fast_hs && (i_fast_data != 8'd0) && in_frame && in_border;

    assign push_req   = cand_v && (o_kp_count < MAX);
    assign occupancy  = (CW+2)'(fifo_count) + (CW+2)'(o_kp_valid);
    assign queue_full = occupancy >= (CW+2)'(Pra_Fifo_Depth);
    assign load       = !fifo_empty && (!o_kp_valid || i_kp_ready);
    assign drained    = fifo_empty && !o_kp_valid && !cand_v;

    fkc_fifo #(.W(32), .DEPTH(Pra_Fifo_Depth)) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (push_req && !queue_full),
        .wr_data ({cand_y, cand_x}),
        .pop     (load),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            vs_d         <= 1'b1;
            hs_d         <= 1'b0;
            x            <= '0;
            y            <= '0;
            cand_v       <= 1'b0;
            cand_x       <= '0;
            cand_y       <= '0;
            o_kp_count   <= '0;
            o_overflow   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            vs_d         <= i_fast_vs;
            hs_d         <= i_fast_hs;
            o_frame_done <= 1'b0;
            cand_v       <= hit;
            cand_x       <= cur_x;
            cand_y       <= cur_y;

            if (i_fast_hs)    x <= sat_inc(cur_x);
            else if (hs_fall) x <= '0;
            else              x <= cur_x;
            if (hs_fall && !vs_rise) y <= sat_inc(y);
            else                     y <= cur_y;

            if (vs_rise) begin
                o_kp_count <= '0;
                o_overflow <= 1'b0;
            end else if (push_req) begin
                if (queue_full) o_overflow <= 1'b1;
                else            o_kp_count <= o_kp_count + 16'd1;
            end

            case (state)
                IDLE:  if (vs_rise) state <= FRAME;
                FRAME: if (vs_fall) begin
                    if (drained) begin
                        state        <= IDLE;
                        o_frame_done <= 1'b1;
                    end else begin
                        state <= FLUSH;
                    end
                end
                FLUSH: if (vs_rise) begin
                    state        <= FRAME;
                    o_frame_done <= 1'b1;
                end else if (drained) begin
                    state        <= IDLE;
                    o_frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_kp_valid <= 1'b0;
            o_kp_x     <= '0;
            o_kp_y     <= '0;
        end else if (load) begin
            o_kp_valid <= 1'b1;
            o_kp_x     <= fifo_rd[15:0];
            o_kp_y     <= fifo_rd[31:16];
        end else if (i_kp_ready) begin
            o_kp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/fast_keypoint_collector.md
# fast_keypoint_collector

Consumer of the FAST/NMS corner stream (vs/hs/8-bit data). It turns the per-pixel corner flags into a queue of (x, y) keypoint coordinates for downstream descriptor blocks (orientation/BRIEF), delivered over a valid/ready handshake. It sits directly after the FAST NMS stage. It counts frame geometry itself, applies a border mask and a per-frame keypoint cap, and buffers keypoints in a FIFO. It signals end-of-frame once every keypoint of the frame has been handed off.

## Interface
- Pra_Image_Width, 640, active pixels per line (hs-high cycles per line)
- Pra_Image_Height, 480, active lines per frame
- Pra_Border, 3, keypoints within this many pixels of any edge are discarded
- Pra_Max_Keypoints, 500, per-frame cap on accepted keypoints
- Pra_Fifo_Depth, 256, keypoint FIFO depth, power of two

Ports:
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_fast_vs  in  1  frame valid, high for the whole frame
- i_fast_hs  in  1  pixel valid, high for each active pixel of a line
- i_fast_data  in  8  corner flag; nonzero = keypoint
- o_kp_valid  out  1  keypoint available
- i_kp_ready  in  1  downstream accepts keypoint
- o_kp_x  out  16  keypoint column, 0-based
- o_kp_y  out  16  keypoint row, 0-based
- o_kp_count  out  16  keypoints accepted in current/last frame
- o_overflow  out  1  sticky: a keypoint was dropped because the FIFO was full
- o_frame_done  out  1  one-cycle pulse when a frame's keypoints are fully drained

## Operation
- All inputs are sampled on the i_clk rising edge. Edges on vs and hs are detected against their previous-cycle values.
- vs rising: x=0, y=0, o_kp_count=0, o_overflow=0; state goes to FRAME.
- Column counter: x increments after each hs-high cycle.
- hs falling: x=0 and y increments. Counters saturate at 16'hFFFF and do not wrap.
- Acceptance: a pixel is accepted when all of the following hold:
  - i_fast_vs=1, i_fast_hs=1, i_fast_data!=0
  - Pra_Border <= x <= Pra_Image_Width-1-Pra_Border
  - Pra_Border <= y <= Pra_Image_Height-1-Pra_Border
  - o_kp_count < Pra_Max_Keypoints
- An accepted pixel is pushed into the FIFO as {y,x} and o_kp_count increments.
- If the FIFO is full when a pixel is accepted, the pixel is dropped, o_kp_count is NOT incremented, and o_overflow is set.
- Keypoints beyond the cap are silently ignored and do not set o_overflow.
- States:
  - IDLE: no frame active.
  - FRAME: vs high.
  - FLUSH: vs low; FIFO and output register not yet empty.
- Transitions:
  - IDLE→FRAME on vs rise.
  - FRAME→FLUSH on vs fall.
  - FLUSH→IDLE when the FIFO and output register are empty; o_frame_done pulses in that cycle.
  - FRAME→IDLE directly on vs fall when already empty, with o_frame_done pulsing on that transition.
- vs rises while in FLUSH: o_frame_done pulses in that cycle and the state goes to FRAME. The previous frame's queued keypoints stay queued ahead of the new frame's. Counters and o_overflow reset as above.
- Output handshake:
  - o_kp_x/o_kp_y come from a registered output stage fed by the FIFO.
  - A transfer occurs on an edge where o_kp_valid=1 and i_kp_ready=1.
  - While o_kp_valid=1 and i_kp_ready=0, o_kp_valid, o_kp_x and o_kp_y hold stable.
  - The output stage refills in the same cycle as a transfer when the FIFO is non-empty, so back-to-back transfers run at 1 per cycle.
- A push and a pop in the same cycle are both honoured. "Full" is evaluated before the pop, so there is no bypass into a full FIFO.

## Timing
- Reset values: o_kp_valid=0, o_kp_x=0, o_kp_y=0, o_kp_count=0, o_overflow=0, o_frame_done=0. State is IDLE and the FIFO is empty.
- Reset asserted mid-frame or mid-drain discards all queued keypoints immediately. After reset is released, the block waits for the next vs rise; a frame already in progress (vs already high) is ignored until vs falls and rises again.
- Latency: a keypoint pixel sampled at edge t is written into the FIFO at edge t+1. With the FIFO and output stage empty, o_kp_valid=1 after edge t+2.
- o_kp_count updates at edge t+1.
- o_frame_done is earliest 1 cycle after the edge at which vs is sampled low, and never before the last keypoint transfer has completed.
- Throughput: 1 keypoint in per cycle, 1 keypoint out per cycle.

## Test plan
- Single corner: 16x8 frame with Pra_Border=3, nonzero data at x=5, y=4, i_kp_ready=1 -> exactly one transfer with x=5, y=4 at t+2; o_kp_count=1; o_frame_done pulses once after vs falls.
- Border mask: corners at (2,4), (12,4), (5,2) and (13,4) on a 16x8 frame -> only (12,4) is delivered; o_kp_count=1.
- Backpressure: 10 adjacent corners on one line with i_kp_ready=0 for 20 cycles, then held at 1 -> 10 in-order transfers x=3..12 at 1 per cycle; outputs stay stable while stalled; no data lost.
- Overflow: Pra_Fifo_Depth=4, 6 corners, i_kp_ready=0 -> 4 delivered later; o_kp_count=4; o_overflow=1 until the next vs rise.
- Cap: Pra_Max_Keypoints=3, 5 valid corners -> 3 delivered; o_kp_count=3; o_overflow=0.
- Reset and frame overlap: assert i_rst with 2 keypoints queued -> all outputs 0 on the next edge, no further transfers. Separately, a new vs rising during FLUSH -> o_frame_done pulses that cycle and old keypoints are delivered before the new frame's.
